// File: rtl/skel_pkg.sv
// Shared types and defaults for the skeletonization pass scheduler.
// Imported by the scheduler, its interface and its address counter.
package skel_pkg;

  localparam int nDefault = 8;
  localparam int bitSizeDefault = 6;
  localparam int pixelWidthDefault = 8;
  localparam int maxPassesDefault = 16;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SCAN,
    CHECK,
    DONE
  } sched_state_t;

  typedef logic [bitSizeDefault:0] pix_addr_t;

endpackage

// File: rtl/skeleton_pass_scheduler_if.sv
// RAM primary port and PE handshake bundle.
// master = scheduler side, slave = RAM/PE side.
interface skeleton_pass_scheduler_if
  import skel_pkg::*;
#(
  parameter int bitSize = bitSizeDefault,
  parameter int pixelWidth = pixelWidthDefault
);

  logic                  mem_we;
  logic [bitSize:0]      mem_addr;
  logic [pixelWidth-1:0] mem_data;
  logic                  pe_req;
  logic [bitSize:0]      pe_addr;
  logic                  pe_subiter;
  logic                  pe_ack;
  logic                  pe_changed;
  logic [pixelWidth-1:0] pe_wdata;

  modport master (
    output mem_we, mem_addr, mem_data,
    output pe_req, pe_addr, pe_subiter,
    input  pe_ack, pe_changed, pe_wdata
  );

  modport slave (
    input  mem_we, mem_addr, mem_data,
    input  pe_req, pe_addr, pe_subiter,
    output pe_ack, pe_changed, pe_wdata
  );

endinterface

// File: rtl/skel_addr_counter.sv
// Clearable, enabled pixel address counter wrapping at N*N.
// termCount flags the last pixel; shared by LOAD and SCAN.
module skel_addr_counter
  import skel_pkg::*;
#(
  parameter int N = nDefault,
  parameter int bitSize = bitSizeDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [bitSize:0] count,
  output logic             termCount
);

  localparam logic [bitSize:0] lastAddr = (bitSize+1)'(N*N-1);

  assign termCount = (count == lastAddr);

  // clear has priority; wrap to 0 after the last pixel
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= termCount ? '0 : count + (bitSize+1)'(1);
    end
  end

endmodule

// File: rtl/skeleton_pass_scheduler.sv
// Skeletonization pass scheduler: load, thinning passes, convergence.
// Optional macro SKEL_CHANGE_STATS_EN adds the changed_total counter.
module skeleton_pass_scheduler
  import skel_pkg::*;
#(
  parameter int N = nDefault,
  parameter int bitSize = bitSizeDefault,
  parameter int pixelWidth = pixelWidthDefault,
  parameter int MAX_PASSES = maxPassesDefault
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_we,
  input  logic [pixelWidth-1:0] load_data,
  input  logic                  start,
  skeleton_pass_scheduler_if.master bus,
  output logic                  loaded,
  output logic                  busy,
  output logic                  done,
  output logic                  timeout,
  output logic                  load_err,
`ifdef SKEL_CHANGE_STATS_EN
  output logic [bitSize+8:0]    changed_total,
`endif
  output logic [7:0]            pass_count
);

  sched_state_t state, stateNext;

  logic [bitSize:0]      count;
  logic                  termCount;
  logic                  cntClr, cntEn;
  logic                  memWe;
  logic [bitSize:0]      memAddr;
  logic [pixelWidth-1:0] memData;
  logic                  loadStart, loadDone, scanStart;
  logic                  ackTake, ackChange;
  logic                  toSub1, passEnd, nextPass, timeoutSet;
  logic                  subiter, changeFlag, gap;
  logic                  peReq;
  logic [7:0]            passInc;

  skel_addr_counter #(
    .N       (N),
    .bitSize (bitSize)
  ) uCounter (
    .clk       (clk),
    .rst       (rst),
    .clr       (cntClr),
    .en        (cntEn),
    .count     (count),
    .termCount (termCount)
  );

  assign passInc = (pass_count == 8'hFF) ? pass_count : pass_count + 8'd1;
  assign peReq   = (state == SCAN) && !gap;
  assign busy    = (state == SCAN) || (state == CHECK);
  assign done    = (state == DONE);

  assign bus.mem_we     = memWe;
  assign bus.mem_addr   = memAddr;
  assign bus.mem_data   = memData;
  assign bus.pe_req     = peReq;
  assign bus.pe_addr    = (state == SCAN) ? count : '0;
  assign bus.pe_subiter = (state == SCAN) && subiter;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // next state, RAM port mux and control strobes
  always_comb begin
    stateNext  = state;
    memWe      = 1'b0;
    memAddr    = '0;
    memData    = '0;
    cntClr     = 1'b0;
    cntEn      = 1'b0;
    loadStart  = 1'b0;
    loadDone   = 1'b0;
    scanStart  = 1'b0;
    ackTake    = 1'b0;
    ackChange  = 1'b0;
    toSub1     = 1'b0;
    passEnd    = 1'b0;
    nextPass   = 1'b0;
    timeoutSet = 1'b0;
    load_err   = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (load_we) begin
          memWe     = 1'b1;
          memData   = load_data;
          cntEn     = 1'b1;
          loadStart = 1'b1;
          stateNext = LOAD;
        end else if (start && loaded) begin
          cntClr    = 1'b1;
          scanStart = 1'b1;
          stateNext = SCAN;
        end
      end
      LOAD: begin
        if (load_we) begin
          memWe   = 1'b1;
          memAddr = count;
          memData = load_data;
          cntEn   = 1'b1;
          if (termCount) begin
            loadDone  = 1'b1;
            stateNext = IDLE;
          end
        end
      end
      SCAN: begin
        load_err = load_we;
        if (peReq && bus.pe_ack) begin
          ackTake = 1'b1;
          cntEn   = 1'b1;
          if (bus.pe_changed) begin
            memWe     = 1'b1;
            memAddr   = count;
            memData   = bus.pe_wdata;
            ackChange = 1'b1;
          end
          if (termCount) stateNext = CHECK;
        end
      end
      CHECK: begin
        load_err = load_we;
        cntClr   = 1'b1;
        if (!subiter) begin
          toSub1    = 1'b1;
          stateNext = SCAN;
        end else begin
          passEnd = 1'b1;
          if (!changeFlag) begin
            stateNext = DONE;
          end else if (int'(passInc) >= MAX_PASSES) begin
            timeoutSet = 1'b1;
            stateNext  = DONE;
          end else begin
            nextPass  = 1'b1;
            stateNext = SCAN;
          end
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  // status, pass bookkeeping and request spacing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loaded     <= 1'b0;
      timeout    <= 1'b0;
      pass_count <= 8'd0;
      subiter    <= 1'b0;
      changeFlag <= 1'b0;
      gap        <= 1'b0;
    end else begin
      gap <= ackTake;
      if (loadStart) begin
        loaded  <= 1'b0;
        timeout <= 1'b0;
      end
      if (loadDone) loaded <= 1'b1;
      if (scanStart) begin
        subiter    <= 1'b0;
        pass_count <= 8'd0;
        changeFlag <= 1'b0;
        timeout    <= 1'b0;
      end
      if (ackChange) changeFlag <= 1'b1;
      if (toSub1) subiter <= 1'b1;
      if (passEnd) begin
        pass_count <= passInc;
        timeout    <= timeoutSet;
      end
      if (nextPass) begin
        subiter    <= 1'b0;
        changeFlag <= 1'b0;
      end
    end
  end

`ifdef SKEL_CHANGE_STATS_EN
  // saturating count of cleared pixels since the last start
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      changed_total <= '0;
    end else if (scanStart) begin
      changed_total <= '0;
    end else if (ackChange && changed_total != '1) begin
      changed_total <= changed_total + (bitSize+9)'(1);
    end
  end
`endif

endmodule
